// File: rtl/tlul_dbg_host_mux.sv
// Minimal TL-UL types plus a 2:1 host mux merging the core data port (host 0)
// and the debug SBA port (host 1) onto one device port, routing D beats by grant order.
package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam logic [2:0] PutFullData   = 3'd0;
    localparam logic [2:0] Get           = 3'd4;
    localparam logic [2:0] AccessAck     = 3'd0;
    localparam logic [2:0] AccessAckData = 3'd1;

endpackage

module tlul_dbg_host_mux #(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          ArbMode        = 1'b0
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  tlul_pkg::tl_h2d_t                   tl_core_i,
    output tlul_pkg::tl_d2h_t                   tl_core_o,
    input  tlul_pkg::tl_h2d_t                   tl_dbg_i,
    output tlul_pkg::tl_d2h_t                   tl_dbg_o,
    output tlul_pkg::tl_h2d_t                   tl_h_o,
    input  tlul_pkg::tl_d2h_t                   tl_h_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                                unexp_rsp_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [MaxOutstanding-1:0] fifo_q, fifo_d;
    logic [PtrW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]           count_q, count_d;
    logic                      last_q, last_d;
    logic                      locked_q, locked_d;
    logic                      lock_host_q, lock_host_d;
    logic                      unexp_q, unexp_d;

    logic full, empty, head, sel, sel_valid;
    logic a_valid_out, a_ready_gnt, a_hs;
    logic d_ready_out, d_hs;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(MaxOutstanding - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    always_comb begin
        full  = (count_q == CntW'(MaxOutstanding));
        empty = (count_q == '0);
        head  = fifo_q[rptr_q];

        // A stalled beat keeps its grant so the presented request stays stable.
        if (locked_q) begin
            sel = lock_host_q;
        end else if (tl_core_i.a_valid && tl_dbg_i.a_valid) begin
            sel = ArbMode ? 1'b1 : ~last_q;
        end else if (tl_dbg_i.a_valid) begin
            sel = 1'b1;
        end else if (tl_core_i.a_valid) begin
            sel = 1'b0;
        end else begin
            sel = last_q;
        end

        sel_valid   = sel ? tl_dbg_i.a_valid : tl_core_i.a_valid;
        a_valid_out = sel_valid & ~full & rst_ni;
        a_ready_gnt = tl_h_i.a_ready & ~full & rst_ni;
        a_hs        = a_valid_out & tl_h_i.a_ready;

        if (empty) begin
            d_ready_out = 1'b1;
        end else begin
            d_ready_out = head ? tl_dbg_i.d_ready : tl_core_i.d_ready;
        end
        d_hs = ~empty & tl_h_i.d_valid & d_ready_out;
    end

    always_comb begin
        tl_h_o         = sel ? tl_dbg_i : tl_core_i;
        tl_h_o.a_valid = a_valid_out;
        tl_h_o.d_ready = d_ready_out;

        tl_core_o         = tl_h_i;
        tl_core_o.d_valid = tl_h_i.d_valid & ~empty & ~head;
        tl_core_o.a_ready = a_ready_gnt & ~sel;

        tl_dbg_o          = tl_h_i;
        tl_dbg_o.d_valid  = tl_h_i.d_valid & ~empty & head;
        tl_dbg_o.a_ready  = a_ready_gnt & sel;
    end

    always_comb begin
        fifo_d      = fifo_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        last_d      = last_q;
        lock_host_d = lock_host_q;
        locked_d    = a_valid_out & ~tl_h_i.a_ready;
        unexp_d     = empty & tl_h_i.d_valid;

        if (locked_d) begin
            lock_host_d = sel;
        end
        if (a_hs) begin
            fifo_d[wptr_q] = sel;
            wptr_d         = ptr_inc(wptr_q);
            last_d         = sel;
        end
        if (d_hs) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({a_hs, d_hs})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            last_q      <= 1'b1;
            locked_q    <= 1'b0;
            lock_host_q <= 1'b0;
            unexp_q     <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            last_q      <= last_d;
            locked_q    <= locked_d;
            lock_host_q <= lock_host_d;
            unexp_q     <= unexp_d;
        end
    end

    assign outstanding_o = count_q;
    assign unexp_rsp_o   = unexp_q;

endmodule

// File: tb/tb_tlul_dbg_host_mux.sv
// Directed bench for tlul_dbg_host_mux: one round-robin and one fixed-priority instance
// share stimulus; expected values are hand-computed per cycle.
module tb_tlul_dbg_host_mux;
    import tlul_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tl_h2d_t core_i, dbg_i;
    tl_d2h_t dev_i;
    tl_d2h_t core_o0, dbg_o0, core_o1, dbg_o1;
    tl_h2d_t h_o0, h_o1;
    logic [1:0] outs0, outs1;
    logic unexp0, unexp1;

    int tests = 0;
    int fails = 0;

    tlul_dbg_host_mux #(.MaxOutstanding(2), .ArbMode(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .tl_core_i(core_i), .tl_core_o(core_o0),
        .tl_dbg_i(dbg_i), .tl_dbg_o(dbg_o0),
        .tl_h_o(h_o0), .tl_h_i(dev_i),
        .outstanding_o(outs0), .unexp_rsp_o(unexp0)
    );

    tlul_dbg_host_mux #(.MaxOutstanding(2), .ArbMode(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .tl_core_i(core_i), .tl_core_o(core_o1),
        .tl_dbg_i(dbg_i), .tl_dbg_o(dbg_o1),
        .tl_h_o(h_o1), .tl_h_i(dev_i),
        .outstanding_o(outs1), .unexp_rsp_o(unexp1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_i         = '0;
        dbg_i          = '0;
        core_i.d_ready = 1'b1;
        dbg_i.d_ready  = 1'b1;
        dev_i          = '0;
        dev_i.a_ready  = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic core_req(input logic [31:0] addr, input logic [31:0] data);
        core_i.a_valid   = 1'b1;
        core_i.a_opcode  = Get;
        core_i.a_address = addr;
        core_i.a_data    = data;
        core_i.a_mask    = 4'hf;
        core_i.a_source  = 8'd0;
    endtask

    task automatic dbg_req(input logic [31:0] addr, input logic [31:0] data);
        dbg_i.a_valid   = 1'b1;
        dbg_i.a_opcode  = Get;
        dbg_i.a_address = addr;
        dbg_i.a_data    = data;
        dbg_i.a_mask    = 4'hf;
        dbg_i.a_source  = 8'd1;
    endtask

    task automatic dev_rsp(input logic [31:0] data);
        dev_i.d_valid  = 1'b1;
        dev_i.d_opcode = AccessAckData;
        dev_i.d_data   = data;
    endtask

    initial begin
        idle();
        // Reset asserted with live-looking inputs
        #1 rst_n = 1'b0;
        core_i.a_valid = 1'b1;
        dbg_i.a_valid  = 1'b1;
        dev_i.d_valid  = 1'b1;
        #2;
        check("rst_h_a_valid", h_o0.a_valid, 1'b0);
        check("rst_core_a_ready", core_o0.a_ready, 1'b0);
        check("rst_dbg_a_ready", dbg_o0.a_ready, 1'b0);
        check("rst_core_d_valid", core_o0.d_valid, 1'b0);
        check("rst_dbg_d_valid", dbg_o0.d_valid, 1'b0);
        check("rst_h_d_ready", h_o0.d_ready, 1'b1);
        check("rst_outstanding", outs0, 2'd0);
        check("rst_unexp", unexp0, 1'b0);
        do_reset();
        @(negedge clk);
        check("rel_unexp", unexp0, 1'b0);
        check("rel_outstanding", outs0, 2'd0);

        // Single core read
        step();
        core_req(32'h1000_0000, 32'h0);
        @(negedge clk);
        check("t1_h_a_valid", h_o0.a_valid, 1'b1);
        check("t1_h_addr", h_o0.a_address, 32'h1000_0000);
        check("t1_core_a_ready", core_o0.a_ready, 1'b1);
        check("t1_outs0", outs0, 2'd0);
        step();
        core_i.a_valid = 1'b0;
        dev_rsp(32'hCAFE_F00D);
        @(negedge clk);
        check("t1_outs1", outs0, 2'd1);
        check("t1_core_d_valid", core_o0.d_valid, 1'b1);
        check("t1_core_d_data", core_o0.d_data, 32'hCAFE_F00D);
        check("t1_dbg_d_valid", dbg_o0.d_valid, 1'b0);
        check("t1_h_d_ready", h_o0.d_ready, 1'b1);
        step();
        dev_i.d_valid = 1'b0;
        @(negedge clk);
        check("t1_outs_back", outs0, 2'd0);

        // Round-robin alternation, responses one cycle behind grants
        do_reset();
        core_req(32'h100, 32'h0);
        dbg_req(32'h200, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rr_addr", h_o0.a_address, (i % 2 == 0) ? 32'h100 : 32'h200);
            check("rr_a_valid", h_o0.a_valid, 1'b1);
            if (i > 0) begin
                check("rr_core_dv", core_o0.d_valid, ((i - 1) % 2 == 0) ? 1'b1 : 1'b0);
                check("rr_dbg_dv", dbg_o0.d_valid, ((i - 1) % 2 == 1) ? 1'b1 : 1'b0);
                check("rr_outs", outs0, 2'd1);
            end
            step();
            dev_rsp(32'hD0 + i);
        end

        // Fixed priority: debug wins while requesting
        do_reset();
        core_req(32'h100, 32'h0);
        dbg_req(32'h200, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fp_addr", h_o1.a_address, 32'h200);
            check("fp_dbg_a_ready", dbg_o1.a_ready, 1'b1);
            check("fp_core_a_ready", core_o1.a_ready, 1'b0);
            step();
            dev_rsp(32'h0);
        end
        dbg_i.a_valid = 1'b0;
        @(negedge clk);
        check("fp_core_gnt", core_o1.a_ready, 1'b1);
        check("fp_core_addr", h_o1.a_address, 32'h100);

        // Grant lock while the device stalls; last grant was core so dbg would win a free tie
        do_reset();
        core_req(32'h50, 32'h0);
        step();
        core_i.a_valid = 1'b0;
        dev_rsp(32'h0);
        step();
        dev_i.d_valid = 1'b0;
        core_req(32'h300, 32'hAAAA_5555);
        dev_i.a_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) dbg_req(32'h400, 32'h0);
            @(negedge clk);
            check("lk_addr", h_o0.a_address, 32'h300);
            check("lk_data", h_o0.a_data, 32'hAAAA_5555);
            check("lk_a_valid", h_o0.a_valid, 1'b1);
            check("lk_core_a_ready", core_o0.a_ready, 1'b0);
            check("lk_dbg_a_ready", dbg_o0.a_ready, 1'b0);
            step();
        end
        dev_i.a_ready = 1'b1;
        @(negedge clk);
        check("lk_core_hs", core_o0.a_ready, 1'b1);
        check("lk_core_addr", h_o0.a_address, 32'h300);
        step();
        core_i.a_valid = 1'b0;
        @(negedge clk);
        check("lk_dbg_addr", h_o0.a_address, 32'h400);
        check("lk_dbg_a_ready", dbg_o0.a_ready, 1'b1);

        // Occupancy limit
        do_reset();
        core_req(32'h600, 32'h0);
        @(negedge clk);
        check("full_a_ready0", core_o0.a_ready, 1'b1);
        step();
        core_req(32'h604, 32'h0);
        @(negedge clk);
        check("full_outs1", outs0, 2'd1);
        step();
        core_req(32'h608, 32'h0);
        dev_rsp(32'h1);
        @(negedge clk);
        check("full_outs2", outs0, 2'd2);
        check("full_a_ready", core_o0.a_ready, 1'b0);
        check("full_a_valid", h_o0.a_valid, 1'b0);
        check("full_core_dv", core_o0.d_valid, 1'b1);
        step();
        dev_i.d_valid = 1'b0;
        @(negedge clk);
        check("full_after_pop_outs", outs0, 2'd1);
        check("full_after_pop_a_ready", core_o0.a_ready, 1'b1);
        check("full_after_pop_a_valid", h_o0.a_valid, 1'b1);
        step();
        core_i.a_valid = 1'b0;
        @(negedge clk);
        check("full_outs_end", outs0, 2'd2);

        // Unexpected response
        do_reset();
        dev_rsp(32'hDEAD);
        @(negedge clk);
        check("ux_core_dv", core_o0.d_valid, 1'b0);
        check("ux_dbg_dv", dbg_o0.d_valid, 1'b0);
        check("ux_d_ready", h_o0.d_ready, 1'b1);
        check("ux_pulse_pre", unexp0, 1'b0);
        step();
        dev_i.d_valid = 1'b0;
        @(negedge clk);
        check("ux_pulse", unexp0, 1'b1);
        step();
        @(negedge clk);
        check("ux_pulse_end", unexp0, 1'b0);

        // Reset with two in flight
        do_reset();
        core_req(32'h700, 32'h0);
        step();
        step();
        @(negedge clk);
        check("mr_outs2", outs0, 2'd2);
        dev_rsp(32'h5);
        rst_n = 1'b0;
        #1;
        check("mr_outs0", outs0, 2'd0);
        check("mr_a_valid", h_o0.a_valid, 1'b0);
        check("mr_core_dv", core_o0.d_valid, 1'b0);
        check("mr_core_a_ready", core_o0.a_ready, 1'b0);
        idle();
        @(posedge clk);
        #1 rst_n = 1'b1;
        core_req(32'h710, 32'h0);
        @(negedge clk);
        check("mr_post_a_valid", h_o0.a_valid, 1'b1);
        check("mr_post_a_ready", core_o0.a_ready, 1'b1);
        step();
        core_i.a_valid = 1'b0;
        dev_rsp(32'h1234_5678);
        @(negedge clk);
        check("mr_post_dv", core_o0.d_valid, 1'b1);
        check("mr_post_data", core_o0.d_data, 32'h1234_5678);
        check("mr_post_outs", outs0, 2'd1);
        step();
        dev_i.d_valid = 1'b0;
        @(negedge clk);
        check("mr_post_outs0", outs0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
